irq_pending_arbiter: RTL and testbench

- Upstream front end for the 8-input high-priority encoder path.
- Captures request events on N lines into a sticky pending register and applies a mask.
- Selects the highest-index pending request, with bit N-1 as top priority, matching the encoder's priority order.
- Presents the selected index on a valid/ready handshake and clears the pending bit on acceptance.

---
 rtl/irq_pkg.sv | 12 +
 rtl/prio_enc_n.sv | 25 ++
 rtl/irq_pending_arbiter.sv | 128 ++++++++++++
 tb/tb_irq_pending_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt pending arbiter.
package irq_pkg;

    localparam int unsigned DefN    = 8;
    localparam int unsigned DefIdxW = 3;

    typedef enum logic {
        StIdle,
        StOffer
    } irq_state_e;

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-index-first priority encoder.
module prio_enc_n
    import irq_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned IDX_W = DefIdxW
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: the last (highest) set bit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Sticky pending register with mask, priority select and valid/ready offer.
// Optional macro IRQ_SYNC_EN adds a two-flop synchronizer on req.
module irq_pending_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned IDX_W = DefIdxW,
    parameter bit          EDGE  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    logic [N-1:0]     req_s;
    logic [N-1:0]     req_q;
    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     pending_d, pending_q;
    logic             overflow_d, overflow_q;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    irq_state_e       state_q;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

`ifdef IRQ_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_s;
        end
    end

    assign rise = EDGE ? (req_s & ~req_q) : req_s;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = out_valid_q && out_ready && (out_idx_q == IDX_W'(i));
        end
    end

    // A new event on the bit being acknowledged survives the clear.
    always_comb begin
        pending_d  = (pending_q & ~clr) | rise;
        overflow_d = |(rise & pending_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    prio_enc_n #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec (pending_q & mask),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Offers are never withdrawn: OFFER ignores En, mask and new events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (En && enc_any) begin
                        out_idx_q   <= enc_idx;
                        out_valid_q <= 1'b1;
                        state_q     <= StOffer;
                    end
                end
                StOffer: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Scoreboard bench for irq_pending_arbiter: expected offer indices are queued
// as requests are driven and checked when the DUT completes a handshake.
module tb_irq_pending_arbiter;

`ifdef IRQ_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] mask;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic       overflow;

    int errors;
    int checks;
    logic [2:0] exp_q[$];

    irq_pending_arbiter #(
        .N     (8),
        .IDX_W (3),
        .EDGE  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .En        (en),
        .req       (req),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        req = v;
        tick();
        req = 8'h00;
        repeat (SyncLat) tick();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Handshake monitor: inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_val("sb_idx", 32'(out_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        en        = 1'b1;
        req       = 8'h00;
        mask      = 8'hFF;
        out_ready = 1'b1;
        #23;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_idx", 32'(out_idx), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request, latency and clear on accept.
        exp_q.push_back(3'd2);
        pulse(8'h04);
        check_val("t1_pend", 32'(pending), 32'h04);
        check_val("t1_nvalid", 32'(out_valid), 32'd0);
        tick();
        check_val("t1_valid", 32'(out_valid), 32'd1);
        check_val("t1_idx", 32'(out_idx), 32'd2);
        tick();
        check_val("t1_done_v", 32'(out_valid), 32'd0);
        check_val("t1_done_p", 32'(pending), 32'd0);
        drain("t1_drain", 4);

        // Two simultaneous requests: priority order and one-cycle gap.
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        pulse(8'h81);
        check_val("t2_pend", 32'(pending), 32'h81);
        tick();
        check_val("t2_idx7", 32'(out_idx), 32'd7);
        tick();
        check_val("t2_gap", 32'(out_valid), 32'd0);
        check_val("t2_pend1", 32'(pending), 32'h01);
        tick();
        check_val("t2_valid0", 32'(out_valid), 32'd1);
        check_val("t2_idx0", 32'(out_idx), 32'd0);
        tick();
        check_val("t2_pend0", 32'(pending), 32'd0);
        drain("t2_drain", 4);

        // Stalled offer must not be preempted by a higher-priority event.
        out_ready = 1'b0;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd6);
        pulse(8'h08);
        tick();
        check_val("t3_idx3", 32'(out_idx), 32'd3);
        repeat (3) tick();
        pulse(8'h40);
        tick();
        check_val("t3_hold_v", 32'(out_valid), 32'd1);
        check_val("t3_hold_i", 32'(out_idx), 32'd3);
        check_val("t3_pend", 32'(pending), 32'h48);
        out_ready = 1'b1;
        tick();
        check_val("t3_gap", 32'(out_valid), 32'd0);
        check_val("t3_pend40", 32'(pending), 32'h40);
        tick();
        check_val("t3_idx6", 32'(out_idx), 32'd6);
        tick();
        check_val("t3_pend0", 32'(pending), 32'd0);
        drain("t3_drain", 4);

        // Repeat event on a still-pending bit merges and flags overflow.
        out_ready = 1'b0;
        exp_q.push_back(3'd1);
        pulse(8'h02);
        tick();
        check_val("t4_idx1", 32'(out_idx), 32'd1);
        check_val("t4_noovf", 32'(overflow), 32'd0);
        req = 8'h02;
        tick();
        req = 8'h00;
        repeat (SyncLat) tick();
        check_val("t4_ovf", 32'(overflow), 32'd1);
        tick();
        check_val("t4_ovf_end", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        tick();
        check_val("t4_ack_v", 32'(out_valid), 32'd0);
        check_val("t4_ack_p", 32'(pending), 32'd0);
        repeat (3) tick();
        check_val("t4_no_dup", 32'(out_valid), 32'd0);
        drain("t4_drain", 4);

        // Masked pending bit is kept and offered once unmasked.
        mask = 8'hFE;
        pulse(8'h01);
        repeat (2) tick();
        check_val("t5_mask_v", 32'(out_valid), 32'd0);
        check_val("t5_mask_p", 32'(pending), 32'h01);
        mask = 8'hFF;
        exp_q.push_back(3'd0);
        tick();
        check_val("t5_unmask", 32'(out_valid), 32'd1);
        tick();
        check_val("t5_done", 32'(pending), 32'd0);
        drain("t5_drain", 4);

        // En low: pending accumulates, no offer until re-enabled.
        en = 1'b0;
        pulse(8'h01);
        repeat (3) tick();
        check_val("t5_en_v", 32'(out_valid), 32'd0);
        check_val("t5_en_p", 32'(pending), 32'h01);
        en = 1'b1;
        exp_q.push_back(3'd0);
        tick();
        check_val("t5_en_on", 32'(out_valid), 32'd1);
        tick();
        check_val("t5_en_done", 32'(pending), 32'd0);
        drain("t5_en_drain", 4);

        // Asynchronous reset while an offer is outstanding.
        out_ready = 1'b0;
        pulse(8'h30);
        tick();
        check_val("t6_offer", 32'(out_idx), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_v", 32'(out_valid), 32'd0);
        check_val("t6_rst_p", 32'(pending), 32'd0);
        check_val("t6_rst_i", 32'(out_idx), 32'd0);
        #4;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check_val("t6_idle_v", 32'(out_valid), 32'd0);
        check_val("t6_idle_p", 32'(pending), 32'd0);
        drain("t6_drain", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
